sync_mem: RTL

- Parametrised, clocked successor to the sorter's combinational scratch memory.
- Single-port RAM with registered read, read-valid flag and error flag.
- After every reset, a clear sequencer writes zero to every word.
- Sits between the sorter control FSM and its data storage. Holds the unsorted input words and the sorted output words.

---
 rtl/sync_mem_pkg.sv | 20 ++
 rtl/sync_mem_array.sv | 44 ++++
 rtl/sync_mem.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sync_mem_pkg.sv
// Shared types for sync_mem: clear-sequencer state, access decode, address width helper.
package sync_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_WR   = 2'd1,
        ACC_RD   = 2'd2,
        ACC_ERR  = 2'd3
    } acc_t;

    function automatic int calc_aw(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_mem_array.sv
// Plain single-port storage: one write port with byte enables, one registered read port.
// Each byte lane is a separate array so byte-enable writes map onto simple RAM columns.
module sync_mem_array
    import sync_mem_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [WIDTH/8-1:0] be,
    input  logic               re,
    input  logic [AW-1:0]      addr,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   rdata
);

    localparam int NB = WIDTH / 8;

    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [7:0] r_mem [DEPTH];
        logic [7:0] r_rd;

        always_ff @(posedge clk) begin
            if (we && be[gi]) begin
                r_mem[addr] <= wdata[gi*8 +: 8];
            end
        end

        // Only the output register is reset; the array contents are zeroed by the clear sequencer.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rd <= '0;
            end else if (re) begin
                r_rd <= r_mem[addr];
            end
        end

        assign rdata[gi*8 +: 8] = r_rd;
    end

endmodule

// File: rtl/sync_mem.sv
// Single-port RAM with registered read, rvalid/err pulses and a post-reset clear sequencer.
// Optional byte write strobes are enabled by defining SYNC_MEM_WSTRB_EN.
module sync_mem
    import sync_mem_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = calc_aw(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               we,
    input  logic               re,
    input  logic [AW:0]        addr,
    input  logic [WIDTH-1:0]   wdata,
`ifdef SYNC_MEM_WSTRB_EN
    input  logic [WIDTH/8-1:0] wstrb,
`endif
    output logic [WIDTH-1:0]   rdata,
    output logic               rvalid,
    output logic               busy,
    output logic               err
);

    localparam logic [AW:0]   DEPTH_A  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_CNT = AW'(DEPTH - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [AW-1:0]        r_cnt;
    logic                 r_rvalid;
    logic                 r_err;
    acc_t                 w_acc;
    logic                 w_busy;
    logic                 w_mem_we;
    logic                 w_mem_re;
    logic [AW-1:0]        w_mem_addr;
    logic [WIDTH-1:0]     w_mem_wdata;
    logic [WIDTH/8-1:0]   w_mem_be;
    logic [WIDTH/8-1:0]   w_strb;

`ifdef SYNC_MEM_WSTRB_EN
    assign w_strb = wstrb;
`else
    assign w_strb = '1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == CLEAR) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == CLEAR && r_cnt == LAST_CNT) begin
            w_state_next = IDLE;
        end
    end

    // Any enabled access during the clear sequence is rejected as an error.
    always_comb begin
        w_acc = ACC_NONE;
        if (en) begin
            if (r_state == CLEAR) begin
                w_acc = ACC_ERR;
            end else if (we && re) begin
                w_acc = ACC_ERR;
            end else if ((we || re) && addr >= DEPTH_A) begin
                w_acc = ACC_ERR;
            end else if (we) begin
                w_acc = ACC_WR;
            end else if (re) begin
                w_acc = ACC_RD;
            end
        end
    end

    always_comb begin
        w_busy      = (r_state == CLEAR);
        w_mem_we    = w_busy || (w_acc == ACC_WR);
        w_mem_re    = (w_acc == ACC_RD);
        w_mem_addr  = w_busy ? r_cnt : addr[AW-1:0];
        w_mem_wdata = w_busy ? '0 : wdata;
        w_mem_be    = w_busy ? '1 : w_strb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= (w_acc == ACC_RD);
            r_err    <= (w_acc == ACC_ERR);
        end
    end

    sync_mem_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_mem_we),
        .be    (w_mem_be),
        .re    (w_mem_re),
        .addr  (w_mem_addr),
        .wdata (w_mem_wdata),
        .rdata (rdata)
    );

    assign rvalid = r_rvalid;
    assign err    = r_err;
    assign busy   = w_busy;

endmodule
